// File: rtl/map9_sequencer.sv
// ============================================================================
// Module  : map9_sequencer
// Brief   : Command sequencer for the map9v3 core. Buffers up to two 9-bit N
//           requests, pulses map_start for START_CYC cycles per request,
//           waits for a fresh done rising edge, captures dp and returns it
//           with the originating N over a valid/ready response interface.
//           Optional watchdog enabled by defining MAP9_SEQ_TIMEOUT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module map9_sequencer #(
   parameter int START_CYC = 3,
   parameter int TIMEOUT   = 1023
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [8:0] req_n,
   output logic       map_start,
   output logic [8:0] map_n,
   input  logic       map_done,
   input  logic [8:0] map_dp,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [8:0] rsp_dp,
   output logic [8:0] rsp_n,
   output logic       rsp_err,
   output logic       busy
);

   localparam logic [2:0] c_st_idle    = 3'd0;
   localparam logic [2:0] c_st_start   = 3'd1;
   localparam logic [2:0] c_st_wait    = 3'd2;
   localparam logic [2:0] c_st_capture = 3'd3;
   localparam logic [2:0] c_st_resp    = 3'd4;

   // START lasts START_CYC cycles: counter runs START_CYC-1 down to 0
   localparam logic [3:0] c_start_load = 4'(START_CYC - 1);

   logic [2:0] r_state;
   logic [3:0] r_cnt;
   logic [8:0] r_fifo [0:1];
   logic       r_wr_ptr;
   logic       r_rd_ptr;
   logic [1:0] r_count;
   logic       r_done_q;
   logic [8:0] r_map_n;
   logic [8:0] r_rsp_n;
   logic [8:0] r_rsp_dp;
   logic       r_rsp_valid;

   logic       w_req_ready;
   logic       w_push;
   logic       w_pop;
   logic       w_done_rise;
   logic       w_timeout;

   assign w_req_ready = (r_count != 2'd2);
   assign w_push      = req_valid & w_req_ready;
   assign w_pop       = (r_state == c_st_idle) & (r_count != 2'd0);
   assign w_done_rise = map_done & ~r_done_q;

   // Two-entry circular request buffer; push and pop may coincide unless full
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_fifo[0] <= 9'd0;
         r_fifo[1] <= 9'd0;
         r_wr_ptr  <= 1'b0;
         r_rd_ptr  <= 1'b0;
         r_count   <= 2'd0;
      end else begin
         if (w_push) begin
            r_fifo[r_wr_ptr] <= req_n;
            r_wr_ptr         <= ~r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Delayed copy of done so only a fresh rising edge triggers a capture
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_done_q <= 1'b0;
      end else begin
         r_done_q <= map_done;
      end
   end

`ifdef MAP9_SEQ_TIMEOUT_EN
   localparam logic [9:0] c_timeout = 10'(TIMEOUT);

   logic [9:0] r_wdog;
   logic       r_rsp_err;

   assign w_timeout = (r_state == c_st_wait) & ~w_done_rise & (r_wdog == c_timeout);

   // Watchdog over WAIT residency and the error flag it raises
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_wdog    <= 10'd0;
         r_rsp_err <= 1'b0;
      end else begin
         if (r_state != c_st_wait) begin
            r_wdog <= 10'd0;
         end else if (r_wdog != c_timeout) begin
            r_wdog <= r_wdog + 10'd1;
         end
         if (w_timeout) begin
            r_rsp_err <= 1'b1;
         end else if ((r_state == c_st_resp) && rsp_ready) begin
            r_rsp_err <= 1'b0;
         end
      end
   end

   assign rsp_err = r_rsp_err;
`else
   assign w_timeout = 1'b0;
   assign rsp_err   = 1'b0;
`endif

   // Main sequencing FSM: launch, wait for done, capture, hold response
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state     <= c_st_idle;
         r_cnt       <= 4'd0;
         r_map_n     <= 9'd0;
         r_rsp_n     <= 9'd0;
         r_rsp_dp    <= 9'd0;
         r_rsp_valid <= 1'b0;
      end else begin
         case (r_state)
            c_st_idle: begin
               if (r_count != 2'd0) begin
                  r_map_n <= r_fifo[r_rd_ptr];
                  r_rsp_n <= r_fifo[r_rd_ptr];
                  r_cnt   <= c_start_load;
                  r_state <= c_st_start;
               end
            end
            c_st_start: begin
               if (r_cnt == 4'd0) begin
                  r_state <= c_st_wait;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            c_st_wait: begin
               if (w_done_rise) begin
                  r_rsp_dp <= map_dp;
                  r_state  <= c_st_capture;
               end else if (w_timeout) begin
                  r_rsp_dp <= 9'd0;
                  r_state  <= c_st_capture;
               end
            end
            c_st_capture: begin
               r_rsp_valid <= 1'b1;
               r_state     <= c_st_resp;
            end
            c_st_resp: begin
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_state     <= c_st_idle;
               end
            end
            default: begin
               r_state <= c_st_idle;
            end
         endcase
      end
   end

   assign req_ready = w_req_ready;
   assign map_start = (r_state == c_st_start);
   assign map_n     = r_map_n;
   assign rsp_valid = r_rsp_valid;
   assign rsp_dp    = r_rsp_dp;
   assign rsp_n     = r_rsp_n;
   assign busy      = (r_state != c_st_idle) | (r_count != 2'd0);

endmodule

`default_nettype wire

// File: tb/tb_map9_sequencer.sv
// ============================================================================
// Module  : tb_map9_sequencer
// Brief   : Directed self-checking bench for map9_sequencer. The bench plays
//           the role of the map9v3 core (drives map_done/map_dp by hand).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_map9_sequencer;

   logic       clock = 1'b0;
   logic       reset;
   logic       req_valid;
   logic       req_ready;
   logic [8:0] req_n;
   logic       map_start;
   logic [8:0] map_n;
   logic       map_done;
   logic [8:0] map_dp;
   logic       rsp_valid;
   logic       rsp_ready;
   logic [8:0] rsp_dp;
   logic [8:0] rsp_n;
   logic       rsp_err;
   logic       busy;

   int n_checks = 0;
   int n_errors = 0;

   map9_sequencer #(
      .START_CYC (3),
      .TIMEOUT   (16)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_n     (req_n),
      .map_start (map_start),
      .map_n     (map_n),
      .map_done  (map_done),
      .map_dp    (map_dp),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_dp    (rsp_dp),
      .rsp_n     (rsp_n),
      .rsp_err   (rsp_err),
      .busy      (busy)
   );

   // free-running clock
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // step until the start pulse has been issued and has ended (state WAIT)
   task automatic wait_wait(input string tag);
      int t = 0;
      while (map_start !== 1'b1 && t < 40) begin tick(); t++; end
      while (map_start === 1'b1 && t < 40) begin tick(); t++; end
      chk({tag, "_reach_wait"}, 16'(t < 40), 16'd1);
   endtask

   // act as the core: one clean done rising edge with the given dp
   task automatic serve(input string tag, input logic [8:0] dp);
      wait_wait(tag);
      map_done = 1'b1;
      map_dp   = dp;
      tick();
      map_done = 1'b0;
      map_dp   = 9'd0;
   endtask

   task automatic wait_rsp(input string tag, input logic [8:0] n, input logic [8:0] dp,
                           input logic err);
      int t = 0;
      while (rsp_valid !== 1'b1 && t < 60) begin tick(); t++; end
      chk({tag, "_rsp_valid"}, 16'(rsp_valid), 16'd1);
      chk({tag, "_rsp_n"}, 16'(rsp_n), 16'(n));
      chk({tag, "_rsp_dp"}, 16'(rsp_dp), 16'(dp));
      chk({tag, "_rsp_err"}, 16'(rsp_err), 16'(err));
   endtask

   task automatic handshake();
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
   endtask

   // directed stimulus sequence
   initial begin
      int bad;
      reset     = 1'b0;
      req_valid = 1'b0;
      req_n     = 9'd0;
      map_done  = 1'b0;
      map_dp    = 9'd0;
      rsp_ready = 1'b0;

      // ---- reset state ----
      repeat (3) tick();
      chk("rst_map_start", 16'(map_start), 16'd0);
      chk("rst_map_n", 16'(map_n), 16'd0);
      chk("rst_rsp_valid", 16'(rsp_valid), 16'd0);
      chk("rst_rsp_dp", 16'(rsp_dp), 16'd0);
      chk("rst_rsp_n", 16'(rsp_n), 16'd0);
      chk("rst_rsp_err", 16'(rsp_err), 16'd0);
      chk("rst_busy", 16'(busy), 16'd0);
      reset = 1'b1;
      tick();
      chk("rel_req_ready", 16'(req_ready), 16'd1);
      chk("rel_busy", 16'(busy), 16'd0);

      // ---- single request N=0x015, exact start pulse and response latency ----
      req_n     = 9'h015;
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      chk("t1_busy", 16'(busy), 16'd1);
      chk("t1_start_c1", 16'(map_start), 16'd0);
      tick();
      chk("t1_start_c2", 16'(map_start), 16'd1);
      chk("t1_map_n", 16'(map_n), 16'h015);
      tick();
      chk("t1_start_c3", 16'(map_start), 16'd1);
      tick();
      chk("t1_start_c4", 16'(map_start), 16'd1);
      tick();
      chk("t1_start_c5", 16'(map_start), 16'd0);
      map_done = 1'b1;
      map_dp   = 9'h0AB;
      tick();
      map_dp = 9'h155;
      chk("t1_valid_early", 16'(rsp_valid), 16'd0);
      tick();
      chk("t1_rsp_valid", 16'(rsp_valid), 16'd1);
      chk("t1_rsp_dp", 16'(rsp_dp), 16'h0AB);
      chk("t1_rsp_n", 16'(rsp_n), 16'h015);
      map_done = 1'b0;
      map_dp   = 9'd0;
      handshake();
      chk("t1_valid_clr", 16'(rsp_valid), 16'd0);
      chk("t1_busy_end", 16'(busy), 16'd0);

      // ---- three back-to-back requests, FIFO fills, in-order responses ----
      req_valid = 1'b1;
      req_n     = 9'h001;
      tick();
      chk("t2_ready_a1", 16'(req_ready), 16'd1);
      req_n = 9'h0FF;
      tick();
      chk("t2_ready_a2", 16'(req_ready), 16'd1);
      chk("t2_map_n1", 16'(map_n), 16'h001);
      req_n = 9'h1FF;
      tick();
      req_valid = 1'b0;
      chk("t2_ready_full", 16'(req_ready), 16'd0);
      serve("t2a", 9'h111);
      wait_rsp("t2a", 9'h001, 9'h111, 1'b0);

      // response held for 20 cycles: stable, no launch
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (rsp_valid !== 1'b1 || rsp_n !== 9'h001 || rsp_dp !== 9'h111 || map_start !== 1'b0)
            bad++;
      end
      chk("t4_hold_stable", 16'(bad), 16'd0);
      chk("t4_still_full", 16'(req_ready), 16'd0);
      handshake();
      chk("t2_gap_start0", 16'(map_start), 16'd0);
      chk("t2_gap_valid0", 16'(rsp_valid), 16'd0);
      tick();
      chk("t2_gap_start1", 16'(map_start), 16'd1);
      chk("t2_map_n2", 16'(map_n), 16'h0FF);
      chk("t2_ready_pop", 16'(req_ready), 16'd1);
      serve("t2b", 9'h122);
      wait_rsp("t2b", 9'h0FF, 9'h122, 1'b0);
      handshake();
      serve("t2c", 9'h133);
      wait_rsp("t2c", 9'h1FF, 9'h133, 1'b0);
      handshake();
      chk("t2_busy_end", 16'(busy), 16'd0);

      // ---- done already high on entry to WAIT ----
      map_done  = 1'b1;
      map_dp    = 9'h077;
      req_n     = 9'h0A5;
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      wait_wait("t3");
      repeat (5) tick();
      chk("t3_no_capture", 16'(rsp_valid), 16'd0);
      chk("t3_busy", 16'(busy), 16'd1);
      map_done = 1'b0;
      tick();
      map_done = 1'b1;
      map_dp   = 9'h0C3;
      tick();
      map_dp = 9'h000;
      tick();
      chk("t3_rsp_valid", 16'(rsp_valid), 16'd1);
      chk("t3_rsp_dp", 16'(rsp_dp), 16'h0C3);
      chk("t3_rsp_n", 16'(rsp_n), 16'h0A5);
      handshake();
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (rsp_valid !== 1'b0 || busy !== 1'b0 || map_start !== 1'b0) bad++;
      end
      chk("t3_single_capture", 16'(bad), 16'd0);
      map_done = 1'b0;

      // ---- reset in WAIT with one entry queued ----
      req_valid = 1'b1;
      req_n     = 9'h033;
      tick();
      req_n = 9'h044;
      tick();
      req_valid = 1'b0;
      wait_wait("t5");
      chk("t5_busy_pre", 16'(busy), 16'd1);
      chk("t5_map_n_pre", 16'(map_n), 16'h033);
      #2;
      reset = 1'b0;
      #1;
      chk("t5_map_start", 16'(map_start), 16'd0);
      chk("t5_map_n", 16'(map_n), 16'd0);
      chk("t5_rsp_n", 16'(rsp_n), 16'd0);
      chk("t5_rsp_dp", 16'(rsp_dp), 16'd0);
      chk("t5_rsp_valid", 16'(rsp_valid), 16'd0);
      chk("t5_busy", 16'(busy), 16'd0);
      chk("t5_req_ready", 16'(req_ready), 16'd1);
      tick();
      reset = 1'b1;
      bad = 0;
      for (int i = 0; i < 30; i++) begin
         if (i == 5)  begin map_done = 1'b1; map_dp = 9'h1AA; end
         if (i == 10) begin map_done = 1'b0; map_dp = 9'h000; end
         tick();
         if (rsp_valid !== 1'b0 || busy !== 1'b0 || map_start !== 1'b0) bad++;
      end
      chk("t5_quiet_after", 16'(bad), 16'd0);

`ifdef MAP9_SEQ_TIMEOUT_EN
      // ---- watchdog: done never arrives ----
      req_n     = 9'h07E;
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      wait_wait("t6");
      wait_rsp("t6to", 9'h07E, 9'h000, 1'b1);
      handshake();
      chk("t6_err_clr", 16'(rsp_err), 16'd0);
      req_n     = 9'h0E7;
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      serve("t6b", 9'h1C2);
      wait_rsp("t6b", 9'h0E7, 9'h1C2, 1'b0);
      handshake();
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
